// File: rtl/demux_stream_1ton_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : demux_stream_1ton_if
// Purpose  : Bundles the producer-side and consumer-side handshake signals
//            of the 1:N stream demultiplexer.
// Signals  : in_valid/in_ready/in_data/in_sel   producer handshake
//            out_valid/out_ready/out_data       NCH consumer handshakes
//            sel_err                            sticky bad-select flag
//            in_bcast                           only with DEMUX_STREAM_BCAST_EN
// Modports : master - testbench/producer+consumers view
//            slave  - demultiplexer view
// Revision : 1.0 - initial release
// ============================================================================
interface demux_stream_1ton_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [SELW-1:0]       in_sel;
  logic [NCH-1:0]        out_valid;
  logic [NCH-1:0]        out_ready;
  logic [NCH*WIDTH-1:0]  out_data;
  logic                  sel_err;
`ifdef DEMUX_STREAM_BCAST_EN
  logic                  in_bcast;
`endif

  modport master (
`ifdef DEMUX_STREAM_BCAST_EN
    output in_bcast,
`endif
    output in_valid,
    input  in_ready,
    output in_data,
    output in_sel,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  sel_err
  );

  modport slave (
`ifdef DEMUX_STREAM_BCAST_EN
    input  in_bcast,
`endif
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_sel,
    output out_valid,
    input  out_ready,
    output out_data,
    output sel_err
  );

endinterface
`default_nettype wire

// File: rtl/demux_stream_1ton.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : demux_stream_1ton
// Purpose  : Routes one valid/ready word stream to one of NCH output
//            channels chosen per word by in_sel. Each channel owns a
//            one-entry registered buffer with its own valid/ready handshake.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            io_bus - demux_stream_1ton_if.slave (producer + consumer side)
// Options  : DEMUX_STREAM_BCAST_EN - adds in_bcast; when high the word is
//            written to every channel once all of them can take it.
// Notes    : in_ready depends combinationally on out_ready of the selected
//            channel(s), so a consumer pop frees the slot in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module demux_stream_1ton #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_stream_1ton_if.slave    io_bus
);

  localparam logic [SELW:0] c_nch_ext = (SELW+1)'(NCH);

  logic [WIDTH-1:0] r_data [NCH];
  logic [NCH-1:0]   r_valid;
  logic             r_sel_err;

  logic [NCH-1:0]   w_hit;
  logic [NCH-1:0]   w_chan_free;
  logic [NCH-1:0]   w_load;
  logic             w_sel_in_range;
  logic             w_uni_ready;
  logic             w_bcast;
  logic             w_in_ready;
  logic             w_xfer;

  // With a power-of-two channel count every select value is legal; the
  // compare is only built when an out-of-range code can actually occur.
  generate
    if (NCH == (1 << SELW)) begin : g_full_range
      assign w_sel_in_range = 1'b1;
    end else begin : g_part_range
      assign w_sel_in_range = ({1'b0, io_bus.in_sel} < c_nch_ext);
    end
  endgenerate

`ifdef DEMUX_STREAM_BCAST_EN
  assign w_bcast = io_bus.in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // A channel can take a word if it is empty or is being popped this cycle.
  assign w_chan_free = ~r_valid | io_bus.out_ready;
  assign w_uni_ready = |(w_hit & w_chan_free);

  // Out-of-range words are always accepted so the producer never deadlocks.
  assign w_in_ready = w_bcast        ? (&w_chan_free) :
                      w_sel_in_range ? w_uni_ready    : 1'b1;
  assign w_xfer     = io_bus.in_valid & w_in_ready;

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign w_hit[k]  = (io_bus.in_sel == SELW'(k));
      assign w_load[k] = w_xfer & (w_bcast | w_hit[k]);
      assign io_bus.out_data[k*WIDTH +: WIDTH] = r_data[k];
    end
  endgenerate

  // Load wins over pop so a full channel sustains one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_load[k]) begin
          r_data[k]  <= io_bus.in_data;
          r_valid[k] <= 1'b1;
        end else if (r_valid[k] && io_bus.out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Sticky until reset: records that a word was dropped for a bad select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_xfer && !w_bcast && !w_sel_in_range) begin
      r_sel_err <= 1'b1;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_valid;
  assign io_bus.sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_1ton.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_demux_stream_1ton
// Purpose  : Self-checking bench for demux_stream_1ton. Instance 0 uses
//            NCH=4, instance 1 uses NCH=3 (so out-of-range selects exist).
//            Vector table, directed corner sequences and a random run
//            against a queue-based reference model.
// Options  : DEMUX_STREAM_BCAST_EN - also exercises broadcast.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_stream_1ton;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_stream_1ton_if #(.WIDTH(8), .NCH(4)) bus0 ();
  demux_stream_1ton_if #(.WIDTH(8), .NCH(3)) bus1 ();

  demux_stream_1ton #(.WIDTH(8), .NCH(4)) dut0 (.clk(clk), .rst_n(rst_n), .io_bus(bus0));
  demux_stream_1ton #(.WIDTH(8), .NCH(3)) dut1 (.clk(clk), .rst_n(rst_n), .io_bus(bus1));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [7:0]  dat;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_v;
    logic [31:0] exp_d;
  } vec_t;
  vec_t tbl [11];

  // Reference model: per-channel queue of words accepted but not yet taken.
  logic [7:0] mq    [2][4][$];
  logic [7:0] mlast [2][4];
  bit         merr  [2];
  int         nch   [2] = '{4, 3};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_sel = '0; bus0.out_ready = '0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_sel = '0; bus1.out_ready = '0;
`ifdef DEMUX_STREAM_BCAST_EN
    bus0.in_bcast = 1'b0;
    bus1.in_bcast = 1'b0;
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      merr[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        mq[i][k].delete();
        mlast[i][k] = '0;
      end
    end
  endtask

  task automatic model_step(input int i, input bit vld, input int sel, input logic [7:0] dat,
                            input logic [3:0] ordy, input bit bc, output bit rdy);
    bit all_free;
    bit free [4];
    all_free = 1'b1;
    for (int k = 0; k < 4; k++) free[k] = 1'b0;
    for (int k = 0; k < nch[i]; k++) begin
      free[k]  = (mq[i][k].size() == 0) || ordy[k];
      all_free = all_free & free[k];
    end
    if (bc)               rdy = all_free;
    else if (sel >= nch[i]) rdy = 1'b1;
    else                  rdy = free[sel];
    for (int k = 0; k < nch[i]; k++)
      if (mq[i][k].size() != 0 && ordy[k]) void'(mq[i][k].pop_front());
    if (vld && rdy) begin
      if (bc) begin
        for (int k = 0; k < nch[i]; k++) begin
          mq[i][k].push_back(dat);
          mlast[i][k] = dat;
        end
      end else if (sel < nch[i]) begin
        mq[i][sel].push_back(dat);
        mlast[i][sel] = dat;
      end else begin
        merr[i] = 1'b1;
      end
    end
  endtask

  task automatic chk_state(input int i, input string tag);
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [3:0]  av;
    logic [31:0] ad;
    logic        ae;
    ev = '0; ed = '0;
    for (int k = 0; k < nch[i]; k++) begin
      ev[k]        = (mq[i][k].size() != 0);
      ed[k*8 +: 8] = (mq[i][k].size() != 0) ? mq[i][k][0] : mlast[i][k];
    end
    if (i == 0) begin av = bus0.out_valid; ad = bus0.out_data; ae = bus0.sel_err; end
    else begin av = {1'b0, bus1.out_valid}; ad = {8'h00, bus1.out_data}; ae = bus1.sel_err; end
    chk($sformatf("%s_valid%0d", tag, i), {28'd0, av}, {28'd0, ev});
    chk($sformatf("%s_data%0d", tag, i), ad, ed);
    chk($sformatf("%s_err%0d", tag, i), {31'd0, ae}, {31'd0, merr[i]});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v0"}, {28'd0, bus0.out_valid}, 32'd0);
    chk({tag, "_d0"}, bus0.out_data, 32'd0);
    chk({tag, "_e0"}, {31'd0, bus0.sel_err}, 32'd0);
    chk({tag, "_v1"}, {29'd0, bus1.out_valid}, 32'd0);
    chk({tag, "_d1"}, {8'd0, bus1.out_data}, 32'd0);
    chk({tag, "_e1"}, {31'd0, bus1.sel_err}, 32'd0);
  endtask

  initial begin
    bit         vld, bc, r0, r1;
    int         sel;
    logic [7:0] dat;
    logic [3:0] ordy;

    //         vld sel  data   ordy     rdy  valid    data after edge
    tbl[0]  = '{1, 2, 8'hA5, 4'b0000, 1, 4'b0100, 32'h00A50000};
    tbl[1]  = '{1, 2, 8'h3C, 4'b0000, 0, 4'b0100, 32'h00A50000};
    tbl[2]  = '{1, 1, 8'h3C, 4'b0000, 1, 4'b0110, 32'h00A53C00};
    tbl[3]  = '{1, 0, 8'h01, 4'b0000, 1, 4'b0111, 32'h00A53C01};
    tbl[4]  = '{1, 0, 8'h02, 4'b0001, 1, 4'b0111, 32'h00A53C02};
    tbl[5]  = '{1, 0, 8'h03, 4'b0001, 1, 4'b0111, 32'h00A53C03};
    tbl[6]  = '{0, 0, 8'hFF, 4'b0001, 1, 4'b0110, 32'h00A53C03};
    tbl[7]  = '{0, 3, 8'hFF, 4'b0110, 1, 4'b0000, 32'h00A53C03};
    tbl[8]  = '{1, 3, 8'h77, 4'b1000, 1, 4'b1000, 32'h77A53C03};
    tbl[9]  = '{1, 3, 8'h88, 4'b0000, 0, 4'b1000, 32'h77A53C03};
    tbl[10] = '{1, 3, 8'h88, 4'b1000, 1, 4'b1000, 32'h88A53C03};

    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("rst_held");
    rst_n = 1'b1;
    step();
    chk_zero("rst_rel");

    // Table: route, backpressure, select switch, pop+load, drain.
    for (int i = 0; i < 11; i++) begin
      bus0.in_valid  = tbl[i].vld;
      bus0.in_sel    = tbl[i].sel;
      bus0.in_data   = tbl[i].dat;
      bus0.out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_rdy", i), {31'd0, bus0.in_ready}, {31'd0, tbl[i].exp_rdy});
      step();
      chk($sformatf("tbl%0d_v", i), {28'd0, bus0.out_valid}, {28'd0, tbl[i].exp_v});
      chk($sformatf("tbl%0d_d", i), bus0.out_data, tbl[i].exp_d);
    end
    idle();

    // Out-of-range select on the 3-channel instance.
    bus1.in_valid = 1'b1; bus1.in_sel = 2'd0; bus1.in_data = 8'h11;
    step();
    bus1.in_sel = 2'b11; bus1.in_data = 8'hEE;
    #1;
    chk("oor_rdy", {31'd0, bus1.in_ready}, 32'd1);
    step();
    chk("oor_err", {31'd0, bus1.sel_err}, 32'd1);
    chk("oor_v", {29'd0, bus1.out_valid}, 32'd1);
    chk("oor_d", {8'd0, bus1.out_data}, 32'h00000011);
    idle();
    repeat (3) step();
    chk("oor_sticky", {31'd0, bus1.sel_err}, 32'd1);

    // Async reset between edges with channels 0 and 1 of instance 0 full.
    bus0.in_valid = 1'b1; bus0.in_sel = 2'd0; bus0.in_data = 8'h21;
    step();
    bus0.in_sel = 2'd1; bus0.in_data = 8'h22;
    step();
    idle();
    chk("pre_arst_v", {28'd0, bus0.out_valid}, 32'h0000000B);
    #1 rst_n = 1'b0;
    #2 chk_zero("arst");
    #1 rst_n = 1'b1;
    @(negedge clk);

`ifdef DEMUX_STREAM_BCAST_EN
    bus0.in_valid = 1'b1; bus0.in_sel = 2'd3; bus0.in_data = 8'h99;
    step();
    bus0.in_bcast = 1'b1; bus0.in_sel = 2'd0; bus0.in_data = 8'h5A; bus0.out_ready = 4'b0000;
    #1;
    chk("bc_stall", {31'd0, bus0.in_ready}, 32'd0);
    bus0.out_ready = 4'b1000;
    #1;
    chk("bc_go", {31'd0, bus0.in_ready}, 32'd1);
    step();
    chk("bc_v", {28'd0, bus0.out_valid}, 32'h0000000F);
    chk("bc_d", bus0.out_data, 32'h5A5A5A5A);
    chk("bc_err", {31'd0, bus0.sel_err}, 32'd0);
    idle();
`endif

    // Random run against the reference model, both instances in lockstep.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int n = 0; n < 400; n++) begin
      vld  = ($urandom % 4) != 0;
      sel  = $urandom_range(0, 3);
      dat  = 8'($urandom);
      ordy = 4'($urandom);
`ifdef DEMUX_STREAM_BCAST_EN
      bc = ($urandom % 8) == 0;
      bus0.in_bcast = bc;
      bus1.in_bcast = bc;
`else
      bc = 1'b0;
`endif
      bus0.in_valid = vld; bus0.in_sel = 2'(sel); bus0.in_data = dat; bus0.out_ready = ordy;
      bus1.in_valid = vld; bus1.in_sel = 2'(sel); bus1.in_data = dat; bus1.out_ready = ordy[2:0];
      #1;
      model_step(0, vld, sel, dat, ordy, bc, r0);
      model_step(1, vld, sel, dat, ordy, bc, r1);
      chk($sformatf("rnd%0d_rdy0", n), {31'd0, bus0.in_ready}, {31'd0, r0});
      chk($sformatf("rnd%0d_rdy1", n), {31'd0, bus1.in_ready}, {31'd0, r1});
      step();
      chk_state(0, $sformatf("rnd%0d", n));
      chk_state(1, $sformatf("rnd%0d", n));
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_stream_1ton.md
Name: demux_stream_1toN

Overview:
- Parametrised successor to the 1:2 gate-level demultiplexer.
- Routes one input word stream to one of NCH output channels chosen by a per-word select.
- Each output channel has a one-entry registered buffer and its own valid/ready handshake.
- Sits between a single producer (e.g. a multiplier result stage) and NCH independent consumers.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- NCH, 4, number of output channels (2..16; need not be a power of two).
- SELW, $clog2(NCH), select width in bits (minimum 1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset; asserting clears state immediately; deassertion synchronised by the integrator.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept the input word this cycle.
- in_data  in  WIDTH  input word.
- in_sel  in  SELW  destination channel index for in_data.
- out_valid  out  NCH  bit k set means channel k buffer holds a word.
- out_ready  in  NCH  bit k set means consumer k takes its word this cycle.
- out_data  out  NCH*WIDTH  channel k word at bits [k*WIDTH +: WIDTH].
- sel_err  out  1  sticky flag: a word with in_sel >= NCH was accepted.

Behaviour:
- Reset values: out_valid=0, out_data=0, sel_err=0. Reset mid-transfer discards all buffered words. No transfer completes in the cycle rst_n is low.
- Input transfer occurs when in_valid & in_ready at a rising edge. Output transfer on channel k occurs when out_valid[k] & out_ready[k].
- in_ready is combinational:
  - if in_sel < NCH: in_ready = !out_valid[in_sel] | out_ready[in_sel];
  - else in_ready = 1.
- Combinational path out_ready -> in_ready is permitted and documented.
- Latency: a word accepted at edge N appears with out_valid[sel]=1 after edge N, i.e. one cycle.
- Per-channel buffer update on each edge, in this priority:
  - Load: input transfer targets k. Then out_data[k] <= in_data and out_valid[k] <= 1. This applies even if channel k also pops in the same cycle, giving full throughput of one word per cycle per channel.
  - Pop: output transfer on k with no load. Then out_valid[k] <= 0 and out_data[k] holds its last value.
  - Otherwise: hold.
- Non-selected channels never change data or valid because of input activity. This differs from the 1:2 gate block, which drives 0 on deselected outputs.
- Out-of-range select (only possible when NCH is not a power of two):
  - the word is accepted and dropped;
  - no channel changes;
  - sel_err <= 1 on that edge; it clears only on reset.
- out_valid[k], once set, stays set until popped. out_data[k] is stable while out_valid[k]=1 and out_ready[k]=0.
- in_valid low: no state change other than pops. in_data and in_sel are don't-care.
- The producer may change in_sel while stalled; in_ready follows the current in_sel.

Optional Feature:
- Macro: DEMUX_STREAM_BCAST_EN.
- Defined:
  - adds input port in_bcast (1 bit);
  - when in_bcast=1, in_sel is ignored and in_ready = AND over k of (!out_valid[k] | out_ready[k]);
  - on transfer, every channel loads in_data and sets out_valid; sel_err is unaffected;
  - when in_bcast=0, behaviour is exactly as above.
- Not defined: port in_bcast is absent and only unicast routing exists.

Test Plan:
- Reset and route:
  - rst_n=0 then 1. Drive in_valid=1, in_sel=2, in_data=8'hA5 with out_ready=4'b0000.
  - Required: in_ready=1. The next cycle gives out_valid=4'b0100 and channel 2 data=8'hA5. Other channels stay 0.
- Backpressure:
  - Channel 2 full with out_ready[2]=0. Drive in_sel=2, in_data=8'h3C.
  - Required: in_ready=0 and channel 2 holds 8'hA5.
  - Switch in_sel=1. Required: in_ready=1 and channel 1 loads 8'h3C the next cycle.
- Simultaneous pop and load:
  - Channel 0 full, out_ready[0]=1 held. Send 8'h01, 8'h02, 8'h03 to sel 0 on consecutive cycles.
  - Required: in_ready=1 every cycle, out_valid[0]=1 continuously, and the consumer sees 01, 02, 03 in order.
- Out-of-range select:
  - NCH=3, in_sel=2'b11, in_valid=1.
  - Required: in_ready=1, out_valid unchanged, sel_err=1 from the next cycle and held until rst_n=0.
- Async reset mid-operation:
  - Channels 0 and 1 full. Pulse rst_n low for 3 ns between clock edges.
  - Required: out_valid=0, out_data=0 and sel_err=0 immediately, without a clock edge.
- Broadcast (with DEMUX_STREAM_BCAST_EN):
  - in_bcast=1, in_data=8'h5A, channel 3 full, out_ready=0.
  - Required: in_ready=0.
  - Set out_ready[3]=1. Required: transfer occurs and all 4 channels show 8'h5A the next cycle.
